wb_trace_fifo: RTL and testbench

- Downstream consumer of the pipeline CPU's write-back stage.
- Captures every architectural register write (destination register index plus write data), taken from the WB-stage RegWrite, write-register and write-data signals.
- Buffers captures in a small FIFO and presents them on a valid/ready stream for a debug port, UART bridge or testbench scoreboard.
- Never stalls the CPU. When the FIFO is full, captures are dropped and counted.

---
 rtl/wb_trace_pkg.sv | 18 +
 rtl/trace_fifo_mem.sv | 28 ++
 rtl/wb_trace_fifo.sv | 179 +++++++++++++++++
 tb/tb_wb_trace_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the write-back trace FIFO.
// WB_TRACE_STAMP_EN adds a 16-bit cycle stamp to each entry.
package wb_trace_pkg;

    localparam int TRACE_REG_W     = 5;
    localparam int TRACE_DATA_W    = 32;
    localparam int TRACE_STAMP_W   = 16;
    localparam int TRACE_DEPTH_DEF = 16;

    typedef struct packed {
        logic [TRACE_REG_W-1:0]   reg_idx;
        logic [TRACE_DATA_W-1:0]  data;
`ifdef WB_TRACE_STAMP_EN
        logic [TRACE_STAMP_W-1:0] stamp;
`endif
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// DEPTH x entry storage: synchronous write, asynchronous read at the read pointer.
// Contents are deliberately not reset.
module trace_fifo_mem
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH_DEF,
    parameter int PTR_W = 4
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [PTR_W-1:0]   i_waddr,
    input  trace_entry_t       i_wdata,
    input  logic [PTR_W-1:0]   i_raddr,
    output trace_entry_t       o_rdata
);

    trace_entry_t mem_q [DEPTH];

    // Write port: one entry per accepted capture.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/wb_trace_fifo.sv
// Captures CPU write-back register writes into a first-word-fall-through FIFO.
// Optional macro WB_TRACE_STAMP_EN adds a per-entry cycle stamp and o_trace_stamp.
module wb_trace_fifo
    import wb_trace_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH_DEF,
    parameter int PTR_W  = 4,
    parameter int DATA_W = TRACE_DATA_W,
    parameter int REG_W  = TRACE_REG_W,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_valid,
    input  logic [REG_W-1:0]  i_wb_reg,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_clr,
    output logic              o_trace_valid,
    input  logic              i_trace_ready,
    output logic [REG_W-1:0]  o_trace_reg,
    output logic [DATA_W-1:0] o_trace_data,
    output logic [PTR_W:0]    o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    output logic [CNT_W-1:0]  o_drop_cnt
`ifdef WB_TRACE_STAMP_EN
    ,
    output logic [TRACE_STAMP_W-1:0] o_trace_stamp
`endif
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
`ifdef WB_TRACE_STAMP_EN
    logic [TRACE_STAMP_W-1:0] stamp_q, stamp_d;
`endif

    logic         cap_s, push_s, pop_s, drop_s, we_s;
    trace_entry_t wr_entry_s;
    trace_entry_t rd_entry_s;

    assign o_trace_valid = ~empty_q;

    // Handshake qualification; $zero writes are neither captured nor dropped.
    always_comb begin
        cap_s  = i_wb_valid && (i_wb_reg != {REG_W{1'b0}});
        pop_s  = (~empty_q) && i_trace_ready;
        push_s = cap_s && ((~full_q) || pop_s);
        drop_s = cap_s && full_q && (~pop_s);
        we_s   = push_s && (~i_clr);
    end

    // Entry assembly for the storage write port.
    always_comb begin
        wr_entry_s         = '0;
        wr_entry_s.reg_idx = i_wb_reg;
        wr_entry_s.data    = i_wb_data;
`ifdef WB_TRACE_STAMP_EN
        wr_entry_s.stamp   = stamp_q;
`endif
    end

    // Next-state for pointers, occupancy and drop status; clear wins over traffic.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        empty_d    = empty_q;
        full_d     = full_q;
        if (i_clr) begin
            wr_ptr_d   = {PTR_W{1'b0}};
            rd_ptr_d   = {PTR_W{1'b0}};
            count_d    = {(PTR_W+1){1'b0}};
            overflow_d = 1'b0;
            drop_cnt_d = {CNT_W{1'b0}};
            empty_d    = 1'b1;
            full_d     = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
            if (drop_s) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != {CNT_W{1'b1}}) begin
                    drop_cnt_d = drop_cnt_q + CNT_W'(1);
                end else begin
                    drop_cnt_d = drop_cnt_q;
                end
            end else begin
                overflow_d = overflow_q;
                drop_cnt_d = drop_cnt_q;
            end
            empty_d = (count_d == {(PTR_W+1){1'b0}});
            full_d  = (count_d == (PTR_W+1)'(DEPTH));
        end
    end

`ifdef WB_TRACE_STAMP_EN
    // Free-running cycle counter, zeroed by clear.
    always_comb begin
        if (i_clr) begin
            stamp_d = {TRACE_STAMP_W{1'b0}};
        end else begin
            stamp_d = stamp_q + TRACE_STAMP_W'(1);
        end
    end
`endif

    // State registers; reset empties the FIFO asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {(PTR_W+1){1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= {CNT_W{1'b0}};
`ifdef WB_TRACE_STAMP_EN
            stamp_q    <= {TRACE_STAMP_W{1'b0}};
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef WB_TRACE_STAMP_EN
            stamp_q    <= stamp_d;
`endif
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (we_s),
        .i_waddr (wr_ptr_q),
        .i_wdata (wr_entry_s),
        .i_raddr (rd_ptr_q),
        .o_rdata (rd_entry_s)
    );

    assign o_trace_reg  = rd_entry_s.reg_idx;
    assign o_trace_data = rd_entry_s.data;
`ifdef WB_TRACE_STAMP_EN
    assign o_trace_stamp = rd_entry_s.stamp;
`endif
    assign o_count    = count_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_overflow = overflow_q;
    assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized and directed bench for wb_trace_fifo against a queue-based reference model.
module tb_wb_trace_fifo;

    localparam int DEPTH = 16;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_wb_valid = 1'b0;
    logic [4:0]  i_wb_reg = 5'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic        i_clr = 1'b0;
    logic        o_trace_valid;
    logic        i_trace_ready = 1'b0;
    logic [4:0]  o_trace_reg;
    logic [31:0] o_trace_data;
    logic [4:0]  o_count;
    logic        o_full;
    logic        o_empty;
    logic        o_overflow;
    logic [15:0] o_drop_cnt;
`ifdef WB_TRACE_STAMP_EN
    logic [15:0] o_trace_stamp;
`endif

    wb_trace_fifo dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_wb_valid    (i_wb_valid),
        .i_wb_reg      (i_wb_reg),
        .i_wb_data     (i_wb_data),
        .i_clr         (i_clr),
        .o_trace_valid (o_trace_valid),
        .i_trace_ready (i_trace_ready),
        .o_trace_reg   (o_trace_reg),
        .o_trace_data  (o_trace_data),
        .o_count       (o_count),
        .o_full        (o_full),
        .o_empty       (o_empty),
        .o_overflow    (o_overflow),
        .o_drop_cnt    (o_drop_cnt)
`ifdef WB_TRACE_STAMP_EN
        ,
        .o_trace_stamp (o_trace_stamp)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [15:0] s;
    } ent_t;

    ent_t        mq[$];
    logic        m_ovf;
    int unsigned m_drops;
    int unsigned m_cyc;
    int          errors = 0;
    int          checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(o_trace_valid), 64'(mq.size() != 0));
        check_eq({tag, "_count"}, 64'(o_count), 64'(mq.size()));
        check_eq({tag, "_full"}, 64'(o_full), 64'(mq.size() == DEPTH));
        check_eq({tag, "_empty"}, 64'(o_empty), 64'(mq.size() == 0));
        check_eq({tag, "_ovf"}, 64'(o_overflow), 64'(m_ovf));
        check_eq({tag, "_drops"}, 64'(o_drop_cnt), 64'(m_drops));
        if (mq.size() != 0) begin
            check_eq({tag, "_reg"}, 64'(o_trace_reg), 64'(mq[0].r));
            check_eq({tag, "_data"}, 64'(o_trace_data), 64'(mq[0].d));
`ifdef WB_TRACE_STAMP_EN
            check_eq({tag, "_stamp"}, 64'(o_trace_stamp), 64'(mq[0].s));
`endif
        end
    endtask

    // Called at a falling edge: check, drive, update model, advance one cycle.
    task automatic step(input string tag, input logic v, input logic [4:0] r,
                        input logic [31:0] d, input logic rdy, input logic clr);
        ent_t e;
        logic cap, pop;
        check_outputs(tag);
        i_wb_valid    = v;
        i_wb_reg      = r;
        i_wb_data     = d;
        i_trace_ready = rdy;
        i_clr         = clr;
        cap = v && (r != 5'd0);
        pop = (mq.size() != 0) && rdy;
        if (clr) begin
            mq.delete();
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (cap) begin
                if (mq.size() < DEPTH) begin
                    e.r = r; e.d = d; e.s = 16'(m_cyc);
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
        end
        m_cyc = clr ? 0 : ((m_cyc + 1) % 65536);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic idle(input string tag, input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 5'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        i_rst_n = 1'b0;
        #1;
        check_eq({tag, "_valid"}, 64'(o_trace_valid), 64'd0);
        check_eq({tag, "_empty"}, 64'(o_empty), 64'd1);
        check_eq({tag, "_count"}, 64'(o_count), 64'd0);
        check_eq({tag, "_full"}, 64'(o_full), 64'd0);
        check_eq({tag, "_ovf"}, 64'(o_overflow), 64'd0);
        check_eq({tag, "_drops"}, 64'(o_drop_cnt), 64'd0);
        i_wb_valid = 1'b0; i_wb_reg = 5'd0; i_wb_data = 32'd0;
        i_trace_ready = 1'b0; i_clr = 1'b0;
        mq.delete(); m_ovf = 1'b0; m_drops = 0; m_cyc = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        int thr;
        logic v, rdy, clr;
        logic [4:0] r;
        m_ovf = 1'b0; m_drops = 0; m_cyc = 0;
        do_reset("por");

        // Basic ordered transfer with ready held high.
        step("basic", 1'b1, 5'd8, 32'h0000_0005, 1'b1, 1'b0);
        step("basic", 1'b1, 5'd9, 32'h0000_000A, 1'b1, 1'b0);
        idle("basic", 3, 1'b1);

        // Writes to $zero are filtered.
        step("zero", 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        idle("zero", 2, 1'b1);

        // 18 captures into a stalled 16-deep FIFO, then drain.
        for (int i = 0; i < 18; i++)
            step("fill", 1'b1, 5'((i % 31) + 1), $urandom, 1'b0, 1'b0);
        idle("drain", 18, 1'b1);

        // Full with simultaneous push and pop.
        for (int i = 0; i < 16; i++)
            step("full", 1'b1, 5'((i % 31) + 1), $urandom, 1'b0, 1'b0);
        step("fullpp", 1'b1, 5'd3, 32'h0000_1234, 1'b1, 1'b0);
        idle("fullpp", 18, 1'b1);

        // Clear with a concurrent capture.
        do_reset("rst2");
        for (int i = 0; i < 5; i++)
            step("clr", 1'b1, 5'(i + 10), $urandom, 1'b0, 1'b0);
        step("clr", 1'b1, 5'd7, 32'h0BAD_F00D, 1'b1, 1'b1);
        idle("clr", 2, 1'b0);

        // Stamps at cycles 10 and 13 after reset; reset mid-drain.
        do_reset("rst3");
        idle("stamp", 10, 1'b0);
        step("stamp", 1'b1, 5'd4, 32'h0000_0010, 1'b0, 1'b0);
        idle("stamp", 2, 1'b0);
        step("stamp", 1'b1, 5'd5, 32'h0000_0013, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("mid", 1'b1, 5'(i + 20), $urandom, 1'b0, 1'b0);
        idle("mid", 2, 1'b1);
        do_reset("rstmid");

        // Random traffic with varying back-pressure.
        thr = 50;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 200) == 0) thr = (i / 200) % 3 == 0 ? 20 : ((i / 200) % 3 == 1 ? 90 : 50);
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rdy = ($urandom_range(0, 99) < thr);
            clr = ($urandom_range(0, 199) == 0);
            step("rand", v, r, $urandom, rdy, clr);
        end
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
